// File: rtl/marie_core_p.sv
// marie_core_p: two-stage (fetch / execute) accumulator processor core.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   imem_addr_o   fetch address (always the PC)
//   imem_rd_o     fetch request, high while running
//   imem_vld_i    imem_data_i is valid this cycle (low = stall)
//   imem_data_i   instruction {literal[DW-1:0], opcode[OPW-1:0]}
//   pa_i          input port, registered once before use
//   pb_o          output port register
//   pb_stb_o      one-cycle pulse after each write of pb_o
//   flag_z_o      zero flag
//   flag_c_o      carry / borrow / error flag
//   halted_o      core has executed HALT; only rst leaves this state
module marie_core_p #(
    parameter int unsigned DW  = 8,
    parameter int unsigned AW  = 8,
    parameter int unsigned OPW = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [AW-1:0]     imem_addr_o,
    output logic              imem_rd_o,
    input  logic              imem_vld_i,
    input  logic [DW+OPW-1:0] imem_data_i,
    input  logic [DW-1:0]     pa_i,
    output logic [DW-1:0]     pb_o,
    output logic              pb_stb_o,
    output logic              flag_z_o,
    output logic              flag_c_o,
    output logic              halted_o
);

    localparam logic [OPW-1:0] OpAdd  = OPW'(8'h00);
    localparam logic [OPW-1:0] OpSub  = OPW'(8'h01);
    localparam logic [OPW-1:0] OpMul  = OPW'(8'h02);
    localparam logic [OPW-1:0] OpDiv  = OPW'(8'h03);
    localparam logic [OPW-1:0] OpShl  = OPW'(8'h04);
    localparam logic [OPW-1:0] OpShr  = OPW'(8'h05);
    localparam logic [OPW-1:0] OpRol  = OPW'(8'h06);
    localparam logic [OPW-1:0] OpRor  = OPW'(8'h07);
    localparam logic [OPW-1:0] OpAnd  = OPW'(8'h08);
    localparam logic [OPW-1:0] OpOr   = OPW'(8'h09);
    localparam logic [OPW-1:0] OpXor  = OPW'(8'h0A);
    localparam logic [OPW-1:0] OpNor  = OPW'(8'h0B);
    localparam logic [OPW-1:0] OpNand = OPW'(8'h0C);
    localparam logic [OPW-1:0] OpXnor = OPW'(8'h0D);
    localparam logic [OPW-1:0] OpGt   = OPW'(8'h0E);
    localparam logic [OPW-1:0] OpEq   = OPW'(8'h0F);
    localparam logic [OPW-1:0] OpOut  = OPW'(8'h10);
    localparam logic [OPW-1:0] OpIn   = OPW'(8'h11);
    localparam logic [OPW-1:0] OpPass = OPW'(8'h12);
    localparam logic [OPW-1:0] OpLda  = OPW'(8'h13);
    localparam logic [OPW-1:0] OpLdb  = OPW'(8'h14);
    localparam logic [OPW-1:0] OpMov  = OPW'(8'h15);
    localparam logic [OPW-1:0] OpJmp  = OPW'(8'h16);
    localparam logic [OPW-1:0] OpJz   = OPW'(8'h17);
    localparam logic [OPW-1:0] OpJc   = OPW'(8'h18);
    localparam logic [OPW-1:0] OpHalt = OPW'(8'h19);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [DW+OPW-1:0] ir_q, ir_d;
    logic              ir_vld_q, ir_vld_d;
    logic [DW-1:0]     a_q, a_d;
    logic [DW-1:0]     b_q, b_d;
    logic [DW-1:0]     pb_q, pb_d;
    logic              pb_stb_q, pb_stb_d;
    logic              z_q, z_d;
    logic              c_q, c_d;
    logic [DW-1:0]     pa_q;

    logic [OPW-1:0]    op;
    logic [DW-1:0]     lit;
    logic [DW:0]       sum;
    logic [2*DW-1:0]   prod;
    logic              set_z;

    assign op   = ir_q[OPW-1:0];
    assign lit  = ir_q[DW+OPW-1:OPW];
    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign prod = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ir_vld_d = 1'b0;
        a_d      = a_q;
        b_d      = b_q;
        pb_d     = pb_q;
        pb_stb_d = 1'b0;
        z_d      = z_q;
        c_d      = c_q;
        set_z    = 1'b0;

        if (state_q == StRun) begin
            // Fetch; a taken branch or HALT below overrides pc_d / ir_vld_d.
            if (imem_vld_i) begin
                ir_d     = imem_data_i;
                ir_vld_d = 1'b1;
                pc_d     = pc_q + AW'(1);
            end

            if (ir_vld_q) begin
                case (op)
                    OpAdd:  begin a_d = sum[DW-1:0]; c_d = sum[DW]; set_z = 1'b1; end
                    OpSub:  begin a_d = a_q - b_q; c_d = (a_q < b_q); set_z = 1'b1; end
                    OpMul:  begin
                        a_d   = prod[DW-1:0];
                        c_d   = |prod[2*DW-1:DW];
                        set_z = 1'b1;
                    end
                    OpDiv:  begin
                        if (b_q == '0) begin
                            a_d = '1;
                            c_d = 1'b1;
                        end else begin
                            a_d = a_q / b_q;
                            c_d = 1'b0;
                        end
                        set_z = 1'b1;
                    end
                    OpShl:  begin a_d = a_q << 1; c_d = a_q[DW-1]; set_z = 1'b1; end
                    OpShr:  begin a_d = a_q >> 1; c_d = a_q[0]; set_z = 1'b1; end
                    OpRol:  begin a_d = {a_q[DW-2:0], a_q[DW-1]}; set_z = 1'b1; end
                    OpRor:  begin a_d = {a_q[0], a_q[DW-1:1]}; set_z = 1'b1; end
                    OpAnd:  begin a_d = a_q & b_q; set_z = 1'b1; end
                    OpOr:   begin a_d = a_q | b_q; set_z = 1'b1; end
                    OpXor:  begin a_d = a_q ^ b_q; set_z = 1'b1; end
                    OpNor:  begin a_d = ~(a_q | b_q); set_z = 1'b1; end
                    OpNand: begin a_d = ~(a_q & b_q); set_z = 1'b1; end
                    OpXnor: begin a_d = ~(a_q ^ b_q); set_z = 1'b1; end
                    OpGt:   begin a_d = (a_q > b_q) ? DW'(1) : '0; set_z = 1'b1; end
                    OpEq:   begin a_d = (a_q == b_q) ? DW'(1) : '0; set_z = 1'b1; end
                    OpOut:  begin pb_d = a_q; pb_stb_d = 1'b1; end
                    OpIn:   begin a_d = pa_q; set_z = 1'b1; end
                    OpPass: begin pb_d = pa_q; pb_stb_d = 1'b1; end
                    OpLda:  begin a_d = lit; set_z = 1'b1; end
                    OpLdb:  b_d = lit;
                    OpMov:  b_d = a_q;
                    // Branches test the flags held before this instruction; the
                    // same-cycle fetch is dropped, leaving one bubble.
                    OpJmp:  begin pc_d = lit[AW-1:0]; ir_vld_d = 1'b0; end
                    OpJz:   if (z_q) begin pc_d = lit[AW-1:0]; ir_vld_d = 1'b0; end
                    OpJc:   if (c_q) begin pc_d = lit[AW-1:0]; ir_vld_d = 1'b0; end
                    OpHalt: begin
                        state_d  = StHalt;
                        pc_d     = pc_q;
                        ir_vld_d = 1'b0;
                    end
                    default: ;
                endcase
            end
        end

        if (set_z) begin
            z_d = (a_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            pc_q     <= '0;
            ir_q     <= '0;
            ir_vld_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            pb_q     <= '0;
            pb_stb_q <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            pa_q     <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ir_vld_q <= ir_vld_d;
            a_q      <= a_d;
            b_q      <= b_d;
            pb_q     <= pb_d;
            pb_stb_q <= pb_stb_d;
            z_q      <= z_d;
            c_q      <= c_d;
            pa_q     <= pa_i;
        end
    end

    assign imem_addr_o = pc_q;
    assign imem_rd_o   = (state_q == StRun);
    assign halted_o    = (state_q == StHalt);
    assign pb_o        = pb_q;
    assign pb_stb_o    = pb_stb_q;
    assign flag_z_o    = z_q;
    assign flag_c_o    = c_q;

endmodule

// File: doc/marie_core_p.md
Name: marie_core_p

Overview:
- Parametrised second-generation accumulator processor core.
- Two-stage pipeline: fetch (F) and execute (E).
- Instruction fetch uses a valid handshake, so the memory may stall the core.
- Adds jumps, flags, HALT, divide-by-zero handling and an output strobe; sits between the instruction ROM and the board I/O ports.

Parameters:
- DW, 8, datapath width: A, B, TREG, ports, literal field.
- AW, 8, program counter / instruction address width; AW <= DW is required.
- OPW, 8, opcode field width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- imem_addr  out  AW  fetch address; always equal to PC
- imem_rd  out  1  fetch request; high in RUN state
- imem_vld  in  1  imem_data valid this cycle
- imem_data  in  DW+OPW  instruction {literal[DW-1:0], opcode[OPW-1:0]}
- pa  in  DW  input port
- pb  out  DW  output port register
- pb_stb  out  1  one-cycle pulse whenever pb is written
- flag_z  out  1  zero flag
- flag_c  out  1  carry/borrow/error flag
- halted  out  1  core is in HALT state

Behaviour:
- Reset (sync):
  - PC, A, B, pb = 0; pb_stb, flag_z, flag_c, halted, ir_vld = 0.
  - State = RUN; pa_q = 0.
  - Reset during a stall or mid-branch discards everything in flight.
- pa is registered into pa_q every cycle. IN reads pa_q, so there is 1 cycle of input latency.
- Fetch (F):
  - If RUN and imem_rd and imem_vld: IR <= imem_data, ir_vld <= 1, PC <= PC+1.
  - Otherwise ir_vld <= 0 and PC holds.
  - PC wraps from 2^AW-1 to 0.
- Execute (E): acts on IR when ir_vld=1. An instruction accepted at edge N has its effects registered at edge N+1.
- Opcodes (result -> A unless stated; lit = IR literal):
  - 00 ADD; C = carry-out.
  - 01 SUB; C = borrow (A<B).
  - 02 MUL; low DW bits of the product; C = 1 if the high half is nonzero.
  - 03 DIV; if B=0: A <= all ones, C = 1.
  - 04 SHL; C = old A[DW-1].
  - 05 SHR; C = old A[0].
  - 06 ROL, 07 ROR; C unchanged.
  - 08 AND, 09 OR, 0A XOR, 0B NOR, 0C NAND, 0D XNOR; C unchanged.
  - 0E GT: A = (A>B) ? 1 : 0, unsigned.
  - 0F EQ: A = (A==B) ? 1 : 0.
  - 10 OUT: pb = A, pb_stb.
  - 11 IN: A = pa_q.
  - 12 PASS: pb = pa_q, pb_stb.
  - 13 LDA lit; 14 LDB lit; 15 MOV: B = A.
  - 16 JMP lit[AW-1:0]; 17 JZ (taken if Z=1); 18 JC (taken if C=1).
  - 19 HALT.
  - Any other opcode is a NOP.
- Flags:
  - Z = (new A == 0) on opcodes 00-0F, 11, 13; otherwise Z holds.
  - C holds on opcodes not listed above.
  - JZ/JC test the flags as they are before the current E-stage instruction updates them.
- Taken branch in E:
  - PC <= target; ir_vld <= 0, which flushes any instruction fetched in the same cycle.
  - One bubble follows. Not-taken branches have no penalty.
  - A target equal to the current PC is legal (spin loop).
- HALT: state -> HALT at the edge. halted = 1, imem_rd = 0, ir_vld cleared. The core remains halted until rst. A, B, pb and flags are frozen.
- pb_stb is high for exactly the one cycle after the writing edge. Back-to-back OUT instructions give a continuous high level, one write per cycle.
- Stall (imem_vld = 0): inserts bubbles. State is preserved; E executes nothing.
- Simultaneous fetch and taken branch: the branch wins, and PC takes the target, not PC+1.

Test Plan:
- Reset, then stream LDA 0x05, LDB 0x03, ADD, OUT with imem_vld=1 -> pb = 0x08, pb_stb pulses once, flag_z = 0, PC = 4 after the stream plus 1 cycle.
- LDA 0xFF, LDB 0x01, ADD -> A = 0x00, flag_z = 1, flag_c = 1; then JZ 0x20 -> next imem_addr = 0x20, exactly one bubble.
- LDA 0x07, LDB 0x00, DIV -> A = 0xFF, flag_c = 1; then LDB 0x02, DIV -> A = 0x7F.
- Hold imem_vld = 0 for 3 cycles between LDA 0x0A and OUT -> PC frozen during the stall, pb = 0x0A, no spurious pb_stb.
- pa = 0x5A, IN, OUT, HALT, then more instructions presented -> pb = 0x5A, halted = 1, imem_rd = 0, later instructions ignored; assert rst -> all outputs 0, RUN.
- Set PC to 0xFF via JMP 0xFF, then a NOP is fetched -> PC wraps to 0x00.
